// File: rtl/eth_tx_sched.sv
// Transmit scheduler in front of the MII MAC: arbitrates ch0/ch1, loads header, issues tx_go, enforces IFG.
// Latency: grant one cycle after a request is sampled in IDLE, tx_go one cycle after grant.
// Backpressure: requests are only sampled in IDLE; the MAC is tracked through mii_tx_en, never stalled.
module eth_tx_sched #(
  parameter int IFG_CYCLES = 24,
  parameter int START_TO   = 16,
  parameter int RR_EN      = 0
) (
  input  logic        mii_tx_clk,
  input  logic        rst,
  input  logic [47:0] src_mac,
  input  logic        req0,
  input  logic        req1,
  input  logic [11:0] len0,
  input  logic [11:0] len1,
  input  logic [47:0] dmac0,
  input  logic [47:0] dmac1,
  input  logic [15:0] ltype0,
  input  logic [15:0] ltype1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic        tx_go,
  output logic [11:0] mac_data_len,
  output logic [47:0] mac_des_mac,
  output logic [47:0] mac_src_mac,
  output logic [15:0] mac_len_type,
  input  logic        mii_tx_en,
  output logic        tx_sel,
  output logic        busy
);

  localparam logic [7:0] LP_IFG      = 8'(IFG_CYCLES);
  localparam logic [7:0] LP_START_TO = 8'(START_TO);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_START, S_WAIT_END, S_IFG} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_last;   // last winner: 1 = ch1, so ch0 takes the first tie
  logic        r_gnt0, r_gnt1, r_done0, r_done1, r_err, r_tx_go, r_sel;
  logic [11:0] r_len;
  logic [47:0] r_dmac, r_smac;
  logic [15:0] r_ltype;

  logic        w_pick1;
  logic        w_any;
  logic [7:0]  w_cnt_inc;

  // Pick the winner among current requesters; round-robin favours the channel that did not win last
  always_comb begin
    w_pick1 = 1'b0;
    if (RR_EN != 0) w_pick1 = req1 & (~req0 | ~r_last);
    else            w_pick1 = req1 & ~req0;
  end

  assign w_any     = req0 | req1;
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  // Scheduler FSM with all outputs registered; pulses default low every cycle
  always_ff @(posedge mii_tx_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_tx_go <= 1'b0;
      r_sel   <= 1'b0;
      r_len   <= 12'd0;
      r_dmac  <= 48'd0;
      r_smac  <= 48'd0;
      r_ltype <= 16'd0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_tx_go <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_sel   <= w_pick1;
            r_last  <= w_pick1;
            r_len   <= w_pick1 ? len1   : len0;
            r_dmac  <= w_pick1 ? dmac1  : dmac0;
            r_ltype <= w_pick1 ? ltype1 : ltype0;
            r_smac  <= src_mac;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt <= 8'd0;
          // An empty frame is retired with an error instead of being started
          if (r_len == 12'd0) begin
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
            r_err   <= 1'b1;
            r_state <= S_IFG;
          end else begin
            r_tx_go <= 1'b1;
            r_state <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (mii_tx_en) begin
            r_state <= S_WAIT_END;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_START_TO) begin
              r_err   <= 1'b1;
              r_done0 <= ~r_sel;
              r_done1 <= r_sel;
              r_cnt   <= 8'd0;
              r_state <= S_IFG;
            end
          end
        end
        S_WAIT_END: begin
          if (!mii_tx_en) begin
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
            r_cnt   <= 8'd0;
            r_state <= S_IFG;
          end
        end
        S_IFG: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == LP_IFG) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign done0        = r_done0;
  assign done1        = r_done1;
  assign err          = r_err;
  assign tx_go        = r_tx_go;
  assign tx_sel       = r_sel;
  assign mac_data_len = r_len;
  assign mac_des_mac  = r_dmac;
  assign mac_src_mac  = r_smac;
  assign mac_len_type = r_ltype;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: one fixed-priority and one round-robin instance, directed stimulus.
// Expected pulse events (with cycle stamp) are queued by stimulus and matched by a negedge monitor.
// MAC models raise mii_tx_en two cycles after tx_go and hold it for six cycles.
module tb_eth_tx_sched;

  localparam logic [5:0] E_G0  = 6'b100000;
  localparam logic [5:0] E_G1  = 6'b010000;
  localparam logic [5:0] E_D0  = 6'b001000;
  localparam logic [5:0] E_D1  = 6'b000100;
  localparam logic [5:0] E_ERR = 6'b000010;
  localparam logic [5:0] E_GO  = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [47:0] src_mac;
  logic [11:0] len0, len1;
  logic [47:0] dmac0, dmac1;
  logic [15:0] ltype0, ltype1;

  logic        a_req0, a_req1, a_en;
  logic        a_gnt0, a_gnt1, a_done0, a_done1, a_err, a_tx_go, a_sel, a_busy;
  logic [11:0] a_len;
  logic [47:0] a_dmac, a_smac;
  logic [15:0] a_ltype;

  logic        b_req0, b_req1, b_en;
  logic        b_gnt0, b_gnt1, b_done0, b_done1, b_err, b_tx_go, b_sel, b_busy;
  logic [11:0] b_len;
  logic [47:0] b_dmac, b_smac;
  logic [15:0] b_ltype;

  eth_tx_sched #(.RR_EN(0)) dut_a (
    .mii_tx_clk(clk), .rst(rst), .src_mac(src_mac),
    .req0(a_req0), .req1(a_req1), .len0(len0), .len1(len1),
    .dmac0(dmac0), .dmac1(dmac1), .ltype0(ltype0), .ltype1(ltype1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
    .err(a_err), .tx_go(a_tx_go), .mac_data_len(a_len), .mac_des_mac(a_dmac),
    .mac_src_mac(a_smac), .mac_len_type(a_ltype), .mii_tx_en(a_en),
    .tx_sel(a_sel), .busy(a_busy));

  eth_tx_sched #(.RR_EN(1)) dut_b (
    .mii_tx_clk(clk), .rst(rst), .src_mac(src_mac),
    .req0(b_req0), .req1(b_req1), .len0(len0), .len1(len1),
    .dmac0(dmac0), .dmac1(dmac1), .ltype0(ltype0), .ltype1(ltype1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
    .err(b_err), .tx_go(b_tx_go), .mac_data_len(b_len), .mac_des_mac(b_dmac),
    .mac_src_mac(b_smac), .mac_len_type(b_ltype), .mii_tx_en(b_en),
    .tx_sel(b_sel), .busy(b_busy));

  typedef struct {
    int          d;
    int          cyc;
    logic [5:0]  ev;
    logic        sel;
    logic [11:0] len;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic mac_a_on = 1'b0;
  logic mac_b_on = 1'b0;

  logic [5:0] a_ev, b_ev;
  assign a_ev = {a_gnt0, a_gnt1, a_done0, a_done1, a_err, a_tx_go};
  assign b_ev = {b_gnt0, b_gnt1, b_done0, b_done1, b_err, b_tx_go};

  always @(posedge clk) cyc <= cyc + 1;

  // MAC model for instance A
  initial begin
    a_en = 1'b0;
    forever begin
      @(negedge clk);
      if (a_tx_go && mac_a_on) begin
        repeat (2) @(negedge clk);
        a_en = 1'b1;
        repeat (6) @(negedge clk);
        a_en = 1'b0;
      end
    end
  end

  // MAC model for instance B
  initial begin
    b_en = 1'b0;
    forever begin
      @(negedge clk);
      if (b_tx_go && mac_b_on) begin
        repeat (2) @(negedge clk);
        b_en = 1'b1;
        repeat (6) @(negedge clk);
        b_en = 1'b0;
      end
    end
  end

  // Monitor: match any pulse (or any expectation due now) against the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [5:0]  ev;
      logic        sel;
      logic [11:0] len;
      int          idx;
      ev  = (d == 0) ? a_ev  : b_ev;
      sel = (d == 0) ? a_sel : b_sel;
      len = (d == 0) ? a_len : b_len;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].d == d && sb[i].cyc == cyc) idx = i;
      if (idx >= 0 || ev != 6'd0) begin
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_event dut%0d cyc=%0d got ev=%b required no pulse", d, cyc, ev);
        end else begin
          if (ev !== sb[idx].ev || sel !== sb[idx].sel || len !== sb[idx].len) begin
            errors++;
            $display("FAIL event dut%0d cyc=%0d got ev=%b sel=%b len=%0d required ev=%b sel=%b len=%0d",
                     d, cyc, ev, sel, len, sb[idx].ev, sb[idx].sel, sb[idx].len);
          end
          sb.delete(idx);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event dut%0d cyc=%0d got nothing required ev=%b", sb[i].d, sb[i].cyc, sb[i].ev);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int d, input int c, input logic [5:0] ev, input logic sel, input logic [11:0] len);
    exp_t e;
    e.d = d; e.cyc = c; e.ev = ev; e.sel = sel; e.len = len;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    src_mac = 48'h0200_0000_00A5;
    len0 = 12'd0; len1 = 12'd0;
    dmac0 = 48'd0; dmac1 = 48'd0;
    ltype0 = 16'd0; ltype1 = 16'd0;
    a_req0 = 1'b0; a_req1 = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_tx_go", a_tx_go, 0);
    chk("rst_tx_sel", a_sel, 0);
    chk("rst_len", a_len, 0);
    chk("rst_dmac", a_dmac, 0);
    chk("rst_smac", a_smac, 0);
    chk("rst_ltype", a_ltype, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame on ch1
    mac_a_on = 1'b1;
    len1 = 12'd8; dmac1 = 48'hFFFF_FFFF_FFFF; ltype1 = 16'h0800;
    a_req1 = 1'b1;
    t = cyc;
    push(0, t + 1, E_G1, 1'b1, 12'd8);
    push(0, t + 2, E_GO, 1'b1, 12'd8);
    push(0, t + 11, E_D1, 1'b1, 12'd8);
    @(negedge clk);
    a_req1 = 1'b0;
    @(negedge clk);
    chk("single_dmac", a_dmac, 48'hFFFF_FFFF_FFFF);
    chk("single_ltype", a_ltype, 16'h0800);
    chk("single_smac", a_smac, 48'h0200_0000_00A5);
    wait_to(t + 34);
    chk("single_busy_ifg_end", a_busy, 1);
    @(negedge clk);
    chk("single_busy_idle", a_busy, 0);
    chk("single_hold_len", a_len, 12'd8);
    chk("single_hold_sel", a_sel, 1);

    // Fixed priority: both held, ch0 wins every time
    len0 = 12'd4; len1 = 12'd5; dmac0 = 48'h0011_2233_4455; ltype0 = 16'h0806;
    a_req0 = 1'b1; a_req1 = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      push(0, t + 1 + 35 * k, E_G0, 1'b0, 12'd4);
      push(0, t + 2 + 35 * k, E_GO, 1'b0, 12'd4);
      push(0, t + 11 + 35 * k, E_D0, 1'b0, 12'd4);
    end
    wait_to(t + 75);
    a_req0 = 1'b0; a_req1 = 1'b0;
    wait_to(t + 108);
    chk("fixed_idle", a_busy, 0);

    // Start timeout: MAC never raises mii_tx_en
    mac_a_on = 1'b0;
    a_req0 = 1'b1;
    t = cyc;
    push(0, t + 1, E_G0, 1'b0, 12'd4);
    push(0, t + 2, E_GO, 1'b0, 12'd4);
    push(0, t + 18, E_D0 | E_ERR, 1'b0, 12'd4);
    @(negedge clk);
    a_req0 = 1'b0;
    wait_to(t + 41);
    chk("timeout_busy_ifg_end", a_busy, 1);
    @(negedge clk);
    chk("timeout_busy_idle", a_busy, 0);

    // Zero-length reject on ch1
    mac_a_on = 1'b1;
    len1 = 12'd0;
    a_req1 = 1'b1;
    t = cyc;
    push(0, t + 1, E_G1, 1'b1, 12'd0);
    push(0, t + 2, E_D1 | E_ERR, 1'b1, 12'd0);
    @(negedge clk);
    a_req1 = 1'b0;
    wait_to(t + 25);
    chk("zero_busy_ifg_end", a_busy, 1);
    @(negedge clk);
    chk("zero_busy_idle", a_busy, 0);

    // Round-robin instance: both held, grants alternate starting with ch0
    mac_b_on = 1'b1;
    len0 = 12'd4; len1 = 12'd5;
    b_req0 = 1'b1; b_req1 = 1'b1;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      logic        ch;
      logic [11:0] l;
      ch = k[0];
      l  = ch ? 12'd5 : 12'd4;
      push(1, t + 1 + 35 * k, ch ? E_G1 : E_G0, ch, l);
      push(1, t + 2 + 35 * k, E_GO, ch, l);
      push(1, t + 11 + 35 * k, ch ? E_D1 : E_D0, ch, l);
    end
    wait_to(t + 110);
    b_req0 = 1'b0; b_req1 = 1'b0;
    wait_to(t + 145);
    chk("rr_idle", b_busy, 0);

    // Reset in the middle of a frame on instance A
    len0 = 12'd7;
    a_req0 = 1'b1;
    t = cyc;
    push(0, t + 1, E_G0, 1'b0, 12'd7);
    push(0, t + 2, E_GO, 1'b0, 12'd7);
    @(negedge clk);
    a_req0 = 1'b0;
    wait_to(t + 7);
    chk("midframe_en_high", a_en, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_tx_go", a_tx_go, 0);
    chk("midrst_len", a_len, 0);
    chk("midrst_dmac", a_dmac, 0);
    chk("midrst_smac", a_smac, 0);
    chk("midrst_sel", a_sel, 0);
    wait_to(t + 9);
    rst = 1'b0;
    wait_to(t + 12);
    len1 = 12'd3; dmac1 = 48'h0A0B_0C0D_0E0F; ltype1 = 16'h86DD;
    a_req1 = 1'b1;
    t = cyc;
    push(0, t + 1, E_G1, 1'b1, 12'd3);
    push(0, t + 2, E_GO, 1'b1, 12'd3);
    push(0, t + 11, E_D1, 1'b1, 12'd3);
    @(negedge clk);
    a_req1 = 1'b0;
    chk("postrst_dmac", a_dmac, 48'h0A0B_0C0D_0E0F);
    chk("postrst_ltype", a_ltype, 16'h86DD);
    wait_to(t + 40);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Transmit scheduler in front of the MII Ethernet MAC. Arbitrates between two frame requesters: ch0, a control/ARP source, and ch1, a bulk payload source.
- Latches the winner's frame header fields and issues a single-cycle tx_go to the MAC.
- Tracks the frame on the MAC's mii_tx_en, then enforces the inter-frame gap before granting again.
- Steers the MAC's payload nibble FIFO mux through tx_sel.

Parameters:
- IFG_CYCLES, 24, idle mii_tx_clk cycles after mii_tx_en falls (12 byte times at 4 bits per clock); legal range 1..255.
- START_TO, 16, cycles allowed from tx_go until mii_tx_en rises before the frame is aborted; legal range 1..255.
- RR_EN, 0, arbitration mode: 0 = fixed priority, ch0 wins; 1 = round-robin between ch0 and ch1.

Ports:
- mii_tx_clk  in  1  MII transmit clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_mac  in  48  local MAC address, copied to mac_src_mac at load.
- req0 / req1  in  1  frame request, level; held until the matching grant.
- len0 / len1  in  12  payload length in nibbles.
- dmac0 / dmac1  in  48  destination MAC.
- ltype0 / ltype1  in  16  length/type field.
- gnt0 / gnt1  out  1  one-cycle grant pulse.
- done0 / done1  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a zero-length reject or a start timeout.
- tx_go  out  1  one-cycle start pulse to the MAC.
- mac_data_len  out  12  registered length to the MAC.
- mac_des_mac  out  48  registered destination MAC to the MAC.
- mac_src_mac  out  48  registered source MAC to the MAC.
- mac_len_type  out  16  registered length/type to the MAC.
- mii_tx_en  in  1  MAC transmit enable, monitored only.
- tx_sel  out  1  active channel, steers the payload FIFO mux.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including mac_* buses and tx_sel.
  - The round-robin last-winner register resets to 1, so ch0 wins the first tie.
  - Reset takes effect mid-frame; the scheduler does not wait for mii_tx_en.
- States: IDLE, LOAD, WAIT_START, WAIT_END, IFG.
- IDLE:
  - Samples req0/req1 every cycle.
  - Winner:
    - With RR_EN=0, ch0 wins whenever req0 is high.
    - With RR_EN=1, a single requester wins outright. With both requesting, the channel that is not the last winner wins.
  - The winner's gnt is pulsed on the same cycle the state moves to LOAD.
  - The winner's len/dmac/ltype and src_mac are captured into the mac_* registers; tx_sel is set to the winner.
  - The last-winner register is updated.
- Zero-length request: the winner with len==0 is still granted. It then pulses done and err together one cycle later, issues no tx_go, and goes directly to IFG.
- LOAD: tx_go=1 for exactly one cycle, then WAIT_START. The timeout counter clears.
- WAIT_START:
  - mii_tx_en==1 moves to WAIT_END.
  - Otherwise the counter increments. When it reaches START_TO, err and done of the active channel pulse and the state moves to IFG.
- WAIT_END: on the first cycle mii_tx_en==0, done of the active channel pulses and the state moves to IFG.
- IFG:
  - Counts IFG_CYCLES cycles, then returns to IDLE.
  - Requests are not sampled here.
  - tx_sel and the mac_* registers hold their values until the next LOAD.
- Request handling:
  - Requests are sampled only in IDLE.
  - Dropping req after grant has no effect.
  - The request fields must be stable only on the grant cycle.
- Same-cycle events: a done pulse never coincides with a gnt pulse; the minimum gap is IFG_CYCLES+1 cycles.
- tx_go never asserts while mii_tx_en is high, because the scheduler waits for the fall.
- Counters are 8 bits wide and saturate; they do not wrap.

Test Plan:
- Single frame: reset, then req1=1, len1=12'd8, dmac1=48'hFFFF_FFFF_FFFF, ltype1=16'h0800. Expected:
  - gnt1 pulses one cycle after req1 is seen.
  - tx_go pulses the next cycle; mac_data_len=8 and tx_sel=1.
  - A MAC model asserts mii_tx_en and drops it; done1 pulses one cycle after the fall.
  - busy stays high for 24 more cycles.
- Fixed priority (RR_EN=0): req0 and req1 held together. Expected grant order 0, 0, 0, ...; gnt1 never pulses while req0 stays high.
- Round-robin (RR_EN=1): both requests held. Expected grants 0, 1, 0, 1. Each new grant occurs at least IFG_CYCLES+1 cycles after the previous done.
- Start timeout: grant ch0 with mii_tx_en held at 0. Expected err and done0 pulse together 16 cycles after tx_go, followed by a 24-cycle IFG.
- Zero length: req1 with len1=0. Expected gnt1, then done1 and err together, with no tx_go.
- Reset mid-frame: assert rst during WAIT_END. Expected busy=0, tx_go=0, mac_* = 0 immediately. After release, a new request is granted normally.
